// File: rtl/nested_loop_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : nested_loop_addr_gen
// Description : Three-level nested loop address generator for the
//               convolution buffer read ports. Walks every (c2, c1, c0)
//               combination, with c0 innermost, and hands out one address
//               per valid/ready handshake. It also emits loop-boundary flags
//               for the PE array's downstream loop counters.
//               Addresses are built incrementally, with no multipliers:
//                 row2_base = base + c2*stride2
//                 row1_base = base + c1*stride1 + c2*stride2
//                 addr      = row1_base + c0
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start              - begin a nest (sampled only when idle)
//               base_addr          - address of iteration (0,0,0)
//               lim0/lim1/lim2     - inclusive loop limits
//               stride1/stride2    - address steps for levels 1 and 2
//               busy, done         - nest in progress / end-of-nest pulse
//               out_valid/out_ready- output handshake
//               addr               - linear buffer address
//               last0/last1/last   - loop-boundary flags, aligned with addr
// Revision    : 1.0 - initial release
// ============================================================================
module nested_loop_addr_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] lim0,
    input  logic [DATA_W-1:0] lim1,
    input  logic [DATA_W-1:0] lim2,
    input  logic [ADDR_W-1:0] stride1,
    input  logic [ADDR_W-1:0] stride2,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              last0,
    output logic              last1,
    output logic              last
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_c0;
    logic [DATA_W-1:0] r_c1;
    logic [DATA_W-1:0] r_c2;
    logic [DATA_W-1:0] r_lim0;
    logic [DATA_W-1:0] r_lim1;
    logic [DATA_W-1:0] r_lim2;
    logic [ADDR_W-1:0] r_stride1;
    logic [ADDR_W-1:0] r_stride2;
    logic [ADDR_W-1:0] r_row1_base;
    logic [ADDR_W-1:0] r_row2_base;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_out_valid;

    logic              w_hs;
    logic              w_last0;
    logic              w_last1;
    logic              w_last;
    logic [ADDR_W-1:0] w_row1_next;
    logic [ADDR_W-1:0] w_row2_next;

    // Flags are qualified with out_valid. Without that, the zeroed counters
    // and limits left after reset or at the end of a nest would show
    // spurious boundary flags while nothing is being presented.
    assign w_last0 = r_out_valid && (r_c0 == r_lim0);
    assign w_last1 = w_last0 && (r_c1 == r_lim1);
    assign w_last  = w_last1 && (r_c2 == r_lim2);
    assign w_hs    = r_out_valid && out_ready;

    // The two wrap targets. Truncation to ADDR_W gives the modulo behaviour.
    assign w_row1_next = r_row1_base + r_stride1;
    assign w_row2_next = r_row2_base + r_stride2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_c0        <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_lim0      <= '0;
            r_lim1      <= '0;
            r_lim2      <= '0;
            r_stride1   <= '0;
            r_stride2   <= '0;
            r_row1_base <= '0;
            r_row2_base <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lim0      <= lim0;
                        r_lim1      <= lim1;
                        r_lim2      <= lim2;
                        r_stride1   <= stride1;
                        r_stride2   <= stride2;
                        r_row1_base <= base_addr;
                        r_row2_base <= base_addr;
                        r_addr      <= base_addr;
                        r_c0        <= '0;
                        r_c1        <= '0;
                        r_c2        <= '0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Without a handshake every register holds, which keeps
                    // addr and the flags stable under backpressure.
                    if (w_hs) begin
                        if (w_last) begin
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_c0        <= '0;
                            r_c1        <= '0;
                            r_c2        <= '0;
                            r_state     <= S_IDLE;
                        end else if (!w_last0) begin
                            r_c0   <= r_c0 + 1'b1;
                            r_addr <= r_addr + 1'b1;
                        end else if (!w_last1) begin
                            r_c0        <= '0;
                            r_c1        <= r_c1 + 1'b1;
                            r_row1_base <= w_row1_next;
                            r_addr      <= w_row1_next;
                        end else begin
                            // Level-2 wrap: the new row-1 base restarts at
                            // the new row-2 base.
                            r_c0        <= '0;
                            r_c1        <= '0;
                            r_c2        <= r_c2 + 1'b1;
                            r_row2_base <= w_row2_next;
                            r_row1_base <= w_row2_next;
                            r_addr      <= w_row2_next;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign addr      = r_addr;
    assign last0     = w_last0;
    assign last1     = w_last1;
    assign last      = w_last;

endmodule
`default_nettype wire
